bk_wide_add_seq: RTL and testbench
==================================

Name: bk_wide_add_seq

Overview:
- Multi-word add sequencer: performs one WORDS*W-bit addition by issuing one W-bit word per cycle to a single 32-bit adder core, least-significant word first, and chaining the carry in a register.
- Sits between a valid/ready operand source and a valid/ready result sink, so wide arithmetic units share one narrow adder instead of instantiating wide ones.

Parameters:
- W, 32, word width fed to the adder core per cycle (fixed to the core width).
- WORDS, 4, number of words per operation (>=2); total operand width WORDS*W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept operands.
- in_a  input  WORDS*W  operand A.
- in_b  input  WORDS*W  operand B.
- in_cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts result.
- out_sum  output  WORDS*W  result.
- out_cout  output  1  carry out of the top word.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, busy=0, word index=0, carry reg=0.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On the in_valid&in_ready edge: latch in_a/in_b, set carry reg=in_cin, set index=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle the adder core sees a[idx], b[idx], carry reg.
  - At the edge: sum word stored to out_sum[idx*W +: W], carry reg <= core cout, idx++.
  - When idx==WORDS-1 at the edge: out_cout <= core cout, go to DONE.
- DONE:
  - out_valid=1.
  - out_sum and out_cout are held stable until out_valid&out_ready; at that edge go to IDLE and drop out_valid.
- Latency: accept edge E0, last word written at edge E(WORDS), out_valid high from the cycle after E(WORDS).
  - Minimum initiation interval is WORDS+2 cycles (DONE handshake cycle, then IDLE accept cycle).
  - No same-cycle result-release/new-accept.
- in_valid while busy is ignored; operands are not captured.
- Arithmetic is unsigned modulo 2^(WORDS*W); the carry out of word k propagates to word k+1 without loss.
- out_sum reads 0 outside DONE only after reset; otherwise it holds the partial or last result. Consumers use out_valid only.
- rst_n low mid-RUN or mid-DONE aborts the operation: no out_valid is produced, and the FSM is in IDLE after release.
- out_ready high outside DONE has no effect.

Optional Feature:
- Macro: BK_WIDE_SEQ_SUB_EN.
- Defined:
  - Adds input port in_sub (1 bit), latched at accept.
  - When in_sub=1, word k uses ~b[k] and carry-in(word 0) = 1 (in_cin is ignored), computing A-B.
  - out_cout=1 means no borrow.
- Undefined: no in_sub port; add only.

Decomposition:
- Package bk_adder_pkg holds:
  - the state enum (ST_IDLE, ST_RUN, ST_DONE);
  - the ADDER_W=32 constant;
  - an index width function clog2(WORDS).
- One sub-module: bk_add32_core, the combinational 32-bit adder (a, b, cin -> sum, cout), instantiated once.
- The FSM, operand registers and carry register stay in bk_wide_add_seq.

Test Plan:
- Full-width wrap: in_a=all 1s (128b), in_b=1, in_cin=0 -> out_sum=0, out_cout=1; out_valid rises exactly 4 edges after accept.
- Cross-word carry: in_a=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, in_b=1 -> out_sum=0x..._0000_0001_0000_0000, out_cout=0.
- Carry-in only: in_a=0, in_b=0, in_cin=1 -> out_sum=1, out_cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> out_sum/out_cout stable, in_ready=0, new operands not captured. Raise out_ready -> one result, then IDLE.
- Reset mid-RUN: pull rst_n low 2 cycles after accept -> outputs at reset values immediately, out_valid never asserted for that operation, in_ready=1 after release.
- (BK_WIDE_SEQ_SUB_EN) in_a=5, in_b=7, in_sub=1 -> out_sum=2^128-2, out_cout=0. in_a=7, in_b=5 -> out_sum=2, out_cout=1.

Source files
------------

// File: rtl/bk_adder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bk_adder_pkg
// Description : Shared state encoding, adder core width and index-width helper
//               for the multi-word add sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package bk_adder_pkg;

  localparam int ADDER_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for a WORDS-entry counter; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bk_add32_core.sv
`default_nettype none
// ============================================================================
// Module      : bk_add32_core
// Description : Combinational ADDER_W-bit adder with carry in and carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module bk_add32_core
  import bk_adder_pkg::*;
(
  input  logic [ADDER_W-1:0] i_a,
  input  logic [ADDER_W-1:0] i_b,
  input  logic               i_cin,
  output logic [ADDER_W-1:0] o_sum,
  output logic               o_cout
);

  logic [ADDER_W:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{ADDER_W{1'b0}}, i_cin};
  assign o_sum  = w_full[ADDER_W-1:0];
  assign o_cout = w_full[ADDER_W];

endmodule
`default_nettype wire

// File: rtl/bk_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : bk_wide_add_seq
// Description : WORDS*W-bit add sequenced one word per cycle through a single
//               narrow adder core, LSW first, with a registered carry chain.
//               Optional macro BK_WIDE_SEQ_SUB_EN adds in_sub (A-B mode).
// Revision    : 1.0 - initial release
// ============================================================================
module bk_wide_add_seq
  import bk_adder_pkg::*;
#(
  parameter int W     = ADDER_W,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORDS*W-1:0] in_a,
  input  logic [WORDS*W-1:0] in_b,
  input  logic               in_cin,
`ifdef BK_WIDE_SEQ_SUB_EN
  input  logic               in_sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORDS*W-1:0] out_sum,
  output logic               out_cout,
  output logic               busy
);

  localparam int IDX_W = clog2(WORDS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORDS - 1);

  state_t             r_state;
  logic [WORDS*W-1:0] r_a;
  logic [WORDS*W-1:0] r_b;
  logic [WORDS*W-1:0] r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;
  logic               r_sub;

  logic [W-1:0]       w_a_word;
  logic [W-1:0]       w_b_word;
  logic [W-1:0]       w_sum_word;
  logic               w_cout;
  logic               w_cin0;
  logic               w_sub_in;

`ifdef BK_WIDE_SEQ_SUB_EN
  assign w_sub_in = in_sub;
  // Subtraction is A + ~B + 1, so the external carry-in is overridden.
  assign w_cin0   = in_sub ? 1'b1 : in_cin;
`else
  assign w_sub_in = 1'b0;
  assign w_cin0   = in_cin;
`endif

  assign w_a_word = r_a[r_idx*W +: W];
  assign w_b_word = r_b[r_idx*W +: W] ^ {W{r_sub}};

  bk_add32_core u_core (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum_word),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
      r_sub   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= w_cin0;
            r_sub   <= w_sub_in;
            r_idx   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[r_idx*W +: W] <= w_sum_word;
          r_carry             <= w_cout;
          r_idx               <= r_idx + IDX_W'(1);
          if (r_idx == C_LAST_IDX) begin
            r_cout  <= w_cout;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_sum   = r_sum;
  assign out_cout  = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_bk_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bk_wide_add_seq
// Description : Self-checking bench for bk_wide_add_seq with an expected-result
//               queue; BK_WIDE_SEQ_SUB_EN enables the subtract vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bk_wide_add_seq;

  localparam int W     = 32;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  bk_wide_add_seq #(.W(W), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef BK_WIDE_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N:0] obs, input logic [N:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drives one operand set at a negedge; the handshake completes on the next posedge.
  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic cin, input logic sub);
    exp_t       e;
    logic [N:0] full;
    @(negedge clk);
    chk("in_ready_before_accept", {{N{1'b0}}, in_ready}, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 1;
    else     full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    e.sum  = full[N-1:0];
    e.cout = full[N];
    sb.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input bit check_lat, input int hold_cycles);
    int   n;
    bit   got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (n < 50 && !got) begin
      @(negedge clk);
      n++;
      if (out_valid === 1'b1) got = 1'b1;
    end
    chk("result_seen", {{N{1'b0}}, got}, 1);
    if (got) begin
      if (check_lat) chk("latency_edges", N'(n - 1), WORDS);
      e = sb.pop_front();
      chk("sum", {1'b0, out_sum}, {1'b0, e.sum});
      chk("cout", {{N{1'b0}}, out_cout}, {{N{1'b0}}, e.cout});
      chk("busy_in_done", {{N{1'b0}}, busy}, 1);
      // Backpressure: new operands offered while the result is held.
      for (int k = 0; k < hold_cycles; k++) begin
        in_valid = 1'b1;
        in_a     = {N{1'b1}} ^ e.sum;
        in_b     = 3;
        in_cin   = 1'b1;
        @(negedge clk);
        chk("hold_valid", {{N{1'b0}}, out_valid}, 1);
        chk("hold_in_ready", {{N{1'b0}}, in_ready}, 0);
        chk("hold_sum", {1'b0, out_sum}, {1'b0, e.sum});
        chk("hold_cout", {{N{1'b0}}, out_cout}, {{N{1'b0}}, e.cout});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("valid_dropped", {{N{1'b0}}, out_valid}, 0);
      chk("ready_after_release", {{N{1'b0}}, in_ready}, 1);
      @(negedge clk);
      chk("idle_not_captured", {{N{1'b0}}, busy}, 0);
    end
  endtask

  initial begin
    bit seen_valid;
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {{N{1'b0}}, in_ready}, 1);
    chk("rst_out_valid", {{N{1'b0}}, out_valid}, 0);
    chk("rst_out_sum", {1'b0, out_sum}, 0);
    chk("rst_out_cout", {{N{1'b0}}, out_cout}, 0);
    chk("rst_busy", {{N{1'b0}}, busy}, 0);
    rst_n = 1'b1;

    // Full-width wrap with latency check
    send({N{1'b1}}, 1, 1'b0, 1'b0);
    collect(1'b1, 0);

    // Carry crossing a word boundary
    send({{(N-32){1'b0}}, 32'hFFFF_FFFF}, 1, 1'b0, 1'b0);
    collect(1'b1, 0);

    // Carry-in only
    send('0, '0, 1'b1, 1'b0);
    collect(1'b1, 0);

    // Ripple through words 1..2 only
    send({32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
         {32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001}, 1'b0, 1'b0);
    collect(1'b1, 0);

    // Random operands
    for (int i = 0; i < 4; i++) begin
      send({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'(i), 1'b0);
      collect(1'b0, 0);
    end

    // Backpressure for 5 cycles while new operands are offered
    send({32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_FFFF},
         {32'h2152_4111, 32'hFEDC_BA98, 32'h7654_3210, 32'h0000_0002}, 1'b1, 1'b0);
    collect(1'b1, 5);

    // Reset two cycles after accept aborts the operation
    send({N{1'b1}}, {N{1'b1}}, 1'b1, 1'b0);
    void'(sb.pop_front());
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_sum", {1'b0, out_sum}, 0);
    chk("abort_out_cout", {{N{1'b0}}, out_cout}, 0);
    chk("abort_busy", {{N{1'b0}}, busy}, 0);
    chk("abort_in_ready", {{N{1'b0}}, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    seen_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_valid = 1'b1;
    end
    chk("abort_no_valid", {{N{1'b0}}, seen_valid}, 0);
    chk("abort_ready_after", {{N{1'b0}}, in_ready}, 1);

    // Normal operation resumes after the abort
    send(100, 23, 1'b0, 1'b0);
    collect(1'b1, 0);

`ifdef BK_WIDE_SEQ_SUB_EN
    send(5, 7, 1'b0, 1'b1);
    collect(1'b1, 0);
    send(7, 5, 1'b0, 1'b1);
    collect(1'b1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
